// File: rtl/t08_mem_sequencer_if.sv
// Shared single-port memory bus between the sequencer (master) and the memory
// interface (slave).
// Handshake: the master holds bus_read or bus_write with stable addr/wdata/sel
// until the slave returns a one-cycle bus_ack; an ack is only meaningful while a
// request is up, and bus_rdata is valid only in the ack cycle.
interface t08_mem_sequencer_if;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_read, bus_write, bus_addr, bus_wdata, bus_sel,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_read, bus_write, bus_addr, bus_wdata, bus_sel,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/t08_mem_sequencer.sv
// Arbitrates the single memory bus between instruction fetch and load/store,
// and releases freeze for exactly one cycle per completed instruction.
module t08_mem_sequencer #(
  parameter logic [31:0] TIMEOUT = 32'd255,
  parameter logic [31:0] NOP     = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       i_en,
  input  logic [31:0]                i_pc,
  input  logic                       i_dmem_read,
  input  logic                       i_dmem_write,
  input  logic [31:0]                i_dmem_addr,
  input  logic [31:0]                i_dmem_wdata,
  input  logic [3:0]                 i_dmem_sel,
  t08_mem_sequencer_if.master        bus,
  output logic [31:0]                o_instr_out,
  output logic                       o_instr_valid,
  output logic [31:0]                o_dmem_rdata,
  output logic                       o_dmem_done,
  output logic                       o_freeze,
  output logic                       o_err,
  output logic [2:0]                 o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_sel;
  logic        r_is_write;
  logic [31:0] r_tmo_cnt;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic [31:0] r_dmem_rdata;
  logic        r_err;

  logic        w_in_bus;
  logic        w_timeout;
  logic        w_complete;
  logic        w_latch_data;
  logic        w_freeze;
  logic        w_done;
  logic        w_bus_read;
  logic        w_bus_write;
  logic [31:0] w_bus_addr;
  logic [31:0] w_bus_wdata;
  logic [3:0]  w_bus_sel;

  assign w_in_bus   = (r_state == S_FETCH) || (r_state == S_DATA);
  assign w_timeout  = (TIMEOUT != 32'd0) && (r_tmo_cnt == (TIMEOUT - 32'd1));
  assign w_complete = w_in_bus && (bus.bus_ack || w_timeout);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Bus outputs decode straight from state so an async reset drops requests at once.
  always_comb begin
    w_next       = r_state;
    w_freeze     = 1'b1;
    w_done       = 1'b0;
    w_latch_data = 1'b0;
    w_bus_read   = 1'b0;
    w_bus_write  = 1'b0;
    w_bus_addr   = 32'd0;
    w_bus_wdata  = 32'd0;
    w_bus_sel    = 4'd0;
    case (r_state)
      S_IDLE: begin
        if (i_en) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        w_bus_read = 1'b1;
        w_bus_addr = i_pc;
        w_bus_sel  = 4'hF;
        if (w_complete) begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (i_dmem_write || i_dmem_read) begin
          w_latch_data = 1'b1;
          w_next       = S_DATA;
        end else begin
          w_freeze = 1'b0;
          w_next   = i_en ? S_FETCH : S_IDLE;
        end
      end
      S_DATA: begin
        w_bus_read  = !r_is_write;
        w_bus_write = r_is_write;
        w_bus_addr  = r_addr;
        w_bus_wdata = r_is_write ? r_wdata : 32'd0;
        w_bus_sel   = r_sel;
        if (w_complete) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_freeze = 1'b0;
        w_done   = 1'b1;
        w_next   = i_en ? S_FETCH : S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_addr        <= 32'd0;
      r_wdata       <= 32'd0;
      r_sel         <= 4'd0;
      r_is_write    <= 1'b0;
      r_tmo_cnt     <= 32'd0;
      r_instr       <= NOP;
      r_instr_valid <= 1'b0;
      r_dmem_rdata  <= 32'd0;
      r_err         <= 1'b0;
    end else begin
      // Store wins when the decoder flags both load and store.
      if (w_latch_data) begin
        r_is_write <= i_dmem_write;
        r_addr     <= i_dmem_addr;
        r_sel      <= i_dmem_sel;
        if (i_dmem_write) begin
          r_wdata <= i_dmem_wdata;
        end
      end

      // FETCH and DATA are never adjacent, so the count is always zero on entry.
      if (!w_in_bus || w_complete) begin
        r_tmo_cnt <= 32'd0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 32'd1;
      end

      if ((r_state == S_FETCH) && w_complete) begin
        r_instr       <= bus.bus_ack ? bus.bus_rdata : NOP;
        r_instr_valid <= 1'b1;
      end else if ((w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_IDLE))) begin
        r_instr_valid <= 1'b0;
      end

      if ((r_state == S_DATA) && w_complete && !r_is_write) begin
        r_dmem_rdata <= bus.bus_ack ? bus.bus_rdata : 32'd0;
      end

      // A real ack in the same cycle as the timeout is a normal completion.
      if (w_complete && !bus.bus_ack) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.bus_read   = w_bus_read;
  assign bus.bus_write  = w_bus_write;
  assign bus.bus_addr   = w_bus_addr;
  assign bus.bus_wdata  = w_bus_wdata;
  assign bus.bus_sel    = w_bus_sel;

  assign o_instr_out    = r_instr;
  assign o_instr_valid  = r_instr_valid;
  assign o_dmem_rdata   = r_dmem_rdata;
  assign o_dmem_done    = w_done;
  assign o_freeze       = w_freeze;
  assign o_err          = r_err;
  assign o_state        = r_state;

endmodule

// File: tb/tb_t08_mem_sequencer.sv
// Randomized bench: a fetch unit, decoder and memory responder around the
// sequencer, with a transaction-level model of expected bus accesses.
module tb_t08_mem_sequencer;
  localparam logic [31:0] TO    = 32'd4;
  localparam logic [31:0] NOP_W = 32'h00000013;
  localparam int W = 72;  // {fetch, last, wr, rd, addr[32], wdata[32], sel[4]}

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        dmem_read = 1'b0;
  logic        dmem_write = 1'b0;
  logic [31:0] dmem_addr = 32'd0;
  logic [31:0] dmem_wdata = 32'd0;
  logic [3:0]  dmem_sel = 4'd0;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] dmem_rdata;
  logic        dmem_done;
  logic        freeze;
  logic        err;
  logic [2:0]  state_dbg;

  t08_mem_sequencer_if bus_if ();

  t08_mem_sequencer #(.TIMEOUT(TO), .NOP(NOP_W)) u_dut (
    .clk           (clk),
    .nrst          (nrst),
    .i_en          (en),
    .i_pc          (pc),
    .i_dmem_read   (dmem_read),
    .i_dmem_write  (dmem_write),
    .i_dmem_addr   (dmem_addr),
    .i_dmem_wdata  (dmem_wdata),
    .i_dmem_sel    (dmem_sel),
    .bus           (bus_if.master),
    .o_instr_out   (instr_out),
    .o_instr_valid (instr_valid),
    .o_dmem_rdata  (dmem_rdata),
    .o_dmem_done   (dmem_done),
    .o_freeze      (freeze),
    .o_err         (err),
    .o_state       (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int             checks = 0;
  int             passed = 0;
  logic [W-1:0]   exp_q[$];
  logic           err_exp = 1'b0;
  logic [31:0]    last_rd_exp = 32'd0;
  bit             drv_on = 1'b0;
  bit             rand_ops = 1'b0;
  bit             rand_lat = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]} + 32'h1234_0001;
  endfunction

  // Driver: decide the next instruction's memory op and queue its expected accesses.
  task automatic issue_next();
    int          op;
    logic        rd;
    logic        wr;
    logic [31:0] a;
    op = rand_ops ? int'($urandom_range(0, 7)) : 0;
    rd = (op == 4) || (op == 5) || (op == 7);
    wr = (op == 6) || (op == 7);
    a  = $urandom;
    dmem_read  = rd;
    dmem_write = wr;
    dmem_addr  = {a[31:2], 2'b00};
    dmem_wdata = $urandom;
    dmem_sel   = 4'($urandom_range(1, 15));
    exp_q.push_back({1'b1, !(rd || wr), 1'b0, 1'b1, pc, 32'd0, 4'hF});
    if (rd || wr)
      exp_q.push_back({1'b0, 1'b1, wr, !wr, dmem_addr, wr ? dmem_wdata : 32'd0, dmem_sel});
  endtask

  // Fetch unit: PC advances after every freeze-low cycle.
  logic adv;
  initial begin
    forever begin
      @(negedge clk);
      adv = nrst && drv_on && (freeze == 1'b0);
      @(posedge clk);
      #1;
      if (adv && drv_on && nrst) begin
        pc = pc + 32'd4;
        issue_next();
      end
    end
  end

  // Memory responder: random latency, occasionally ack in the timeout cycle or never.
  int rcnt = 0;
  int lat = 0;
  int pick;
  initial begin
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!nrst || !(bus_if.bus_read || bus_if.bus_write)) begin
        bus_if.bus_ack = 1'b0;
        rcnt = 0;
      end else begin
        if (rcnt == 0) begin
          pick = int'($urandom_range(0, 19));
          if (!rand_lat)      lat = 0;
          else if (pick == 0) lat = 99;
          else if (pick == 1) lat = int'(TO) - 1;
          else                lat = int'($urandom_range(0, TO - 2));
        end
        if (rcnt == lat) begin
          bus_if.bus_ack   = 1'b1;
          bus_if.bus_rdata = mem_word(bus_if.bus_addr);
        end else begin
          bus_if.bus_ack   = 1'b0;
          bus_if.bus_rdata = $urandom;
        end
        rcnt++;
      end
    end
  end

  // Scoreboard monitor
  logic [W-1:0] e;
  bit           post_v = 1'b0;
  bit           post_fetch;
  bit           post_last;
  logic [31:0]  post_data;
  int           req_cyc = 0;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!nrst) begin
        post_v  = 1'b0;
        req_cyc = 0;
        continue;
      end
      if (post_v) begin
        chk("freeze_after_access", freeze, post_last ? 32'd0 : 32'd1);
        chk("dmem_done_after_access", dmem_done, (post_last && !post_fetch) ? 32'd1 : 32'd0);
        if (post_fetch) begin
          chk("instr_out", instr_out, post_data);
          chk("instr_valid", instr_valid, 32'd1);
        end else begin
          chk("dmem_rdata", dmem_rdata, last_rd_exp);
        end
        chk("err", err, err_exp);
        post_v = 1'b0;
      end else begin
        chk("freeze_hold", freeze, 32'd1);
        chk("dmem_done_idle", dmem_done, 32'd0);
      end
      if (bus_if.bus_read || bus_if.bus_write) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_request: rd=%b wr=%b addr=%h, expected no request", bus_if.bus_read, bus_if.bus_write, bus_if.bus_addr);
        end else begin
          e = exp_q[0];
          chk("bus_read", bus_if.bus_read, e[68]);
          chk("bus_write", bus_if.bus_write, e[69]);
          chk("bus_addr", bus_if.bus_addr, e[67:36]);
          chk("bus_sel", bus_if.bus_sel, e[3:0]);
          if (e[69]) chk("bus_wdata", bus_if.bus_wdata, e[35:4]);
          req_cyc++;
          if (bus_if.bus_ack || req_cyc == int'(TO)) begin
            void'(exp_q.pop_front());
            post_v     = 1'b1;
            post_fetch = e[71];
            post_last  = e[70];
            if (e[71]) post_data = bus_if.bus_ack ? mem_word(e[67:36]) : NOP_W;
            else if (e[68]) last_rd_exp = bus_if.bus_ack ? mem_word(e[67:36]) : 32'd0;
            if (!bus_if.bus_ack) err_exp = 1'b1;
            req_cyc = 0;
          end
        end
      end else begin
        req_cyc = 0;
      end
    end
  end

  bit found;
  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #2;
    chk("rst_freeze", freeze, 32'd1);
    chk("rst_bus_read", bus_if.bus_read, 32'd0);
    chk("rst_bus_write", bus_if.bus_write, 32'd0);
    chk("rst_bus_addr", bus_if.bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
    chk("rst_bus_sel", bus_if.bus_sel, 32'd0);
    chk("rst_instr_out", instr_out, NOP_W);
    chk("rst_instr_valid", instr_valid, 32'd0);
    chk("rst_dmem_rdata", dmem_rdata, 32'd0);
    chk("rst_dmem_done", dmem_done, 32'd0);
    chk("rst_err", err, 32'd0);

    // Single-cycle memory, no data ops: freeze 1,0 and fetch addresses 0,4,8,...
    @(posedge clk);
    #1;
    pc = 32'd0;
    issue_next();
    nrst = 1'b1;
    en = 1'b1;
    drv_on = 1'b1;
    repeat (12) @(posedge clk);

    // Random ops and latencies, with en dropped mid-instruction several times
    #1;
    rand_ops = 1'b1;
    rand_lat = 1'b1;
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(80, 160)) @(posedge clk);
      #1;
      en = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
        @(negedge clk);
        #2;
        if (!freeze) found = 1'b1;
      end
      chk("en_drop_completes", found, 32'd1);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        #2;
        chk("parked_bus_read", bus_if.bus_read, 32'd0);
        chk("parked_bus_write", bus_if.bus_write, 32'd0);
        chk("parked_freeze", freeze, 32'd1);
        chk("parked_instr_valid", instr_valid, 32'd0);
      end
      @(posedge clk);
      #1;
      en = 1'b1;
    end

    // Reset in the middle of a store
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      #2;
      if (bus_if.bus_write) found = 1'b1;
    end
    chk("found_store", found, 32'd1);
    drv_on = 1'b0;
    nrst = 1'b0;
    #1;
    chk("rst_drop_write", bus_if.bus_write, 32'd0);
    chk("rst_drop_read", bus_if.bus_read, 32'd0);
    chk("rst_async_freeze", freeze, 32'd1);
    exp_q.delete();
    err_exp = 1'b0;
    last_rd_exp = 32'd0;
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    @(negedge clk);
    #2;
    chk("post_rst_freeze", freeze, 32'd1);
    chk("post_rst_instr_valid", instr_valid, 32'd0);
    chk("post_rst_err", err, 32'd0);
    chk("post_rst_instr_out", instr_out, NOP_W);
    chk("post_rst_bus_read", bus_if.bus_read, 32'd0);

    // Restart after reset
    @(posedge clk);
    #1;
    pc = 32'd0;
    issue_next();
    en = 1'b1;
    drv_on = 1'b1;
    repeat (150) @(posedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
